// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle rv32i control unit.
// Pure declarations: no logic, no latency.
// No flow control of its own; consumers own the handshakes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXR, S_EXI, S_ALUWB, S_BEQ, S_JAL, S_CSR, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_LOAD, CLS_STORE, CLS_OP, CLS_OPIMM, CLS_BRANCH, CLS_JAL, CLS_SYSTEM, CLS_ILL
    } op_class_t;

    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_OP     = 7'd51;
    localparam logic [6:0] OPC_OPIMM  = 7'd19;
    localparam logic [6:0] OPC_BRANCH = 7'd99;
    localparam logic [6:0] OPC_JAL    = 7'd111;
    localparam logic [6:0] OPC_SYSTEM = 7'd115;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] PC_ALU     = 2'b00;
    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_TRAP    = 2'b10;

    localparam logic [1:0] A_PC       = 2'b00;
    localparam logic [1:0] A_OLDPC    = 2'b01;
    localparam logic [1:0] A_RS1      = 2'b10;

    localparam logic [1:0] B_RS2      = 2'b00;
    localparam logic [1:0] B_IMM      = 2'b01;
    localparam logic [1:0] B_FOUR     = 2'b10;

    localparam logic [1:0] SEL_ADD    = 2'b00;
    localparam logic [1:0] SEL_SUB    = 2'b01;
    localparam logic [1:0] SEL_FUNCT  = 2'b10;

    localparam logic [1:0] WB_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_MEM     = 2'b01;
    localparam logic [1:0] WB_PC4     = 2'b10;

    localparam logic [1:0] MOCSR_CSR  = 2'b01;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_BUS  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_w;
        logic       adr_s;
        logic       ir_w;
        logic       pc_w;
        logic       branch;
        logic [1:0] pc_s;
        logic [1:0] alu_a_s;
        logic [1:0] alu_b_s;
        logic [1:0] sel;
        logic [1:0] dato_s;
        logic [1:0] mocsr;
        logic       reg_w;
        logic       trap;
        logic [1:0] cause;
        logic       retire;
    } ctrl_t;

endpackage

// File: rtl/op_class.sv
// Opcode to instruction class decoder with legality flag.
// Purely combinational, zero latency.
// No backpressure; output follows op_code directly.
module op_class
    import ctrl_pkg::*;
#(
    parameter int CSR_EN = 1
) (
    input  logic [6:0] op_code,
    output op_class_t  op_cls,
    output logic       legal
);

    always_comb begin
        op_cls = CLS_ILL;
        case (op_code)
            OPC_LOAD:   op_cls = CLS_LOAD;
            OPC_STORE:  op_cls = CLS_STORE;
            OPC_OP:     op_cls = CLS_OP;
            OPC_OPIMM:  op_cls = CLS_OPIMM;
            OPC_BRANCH: op_cls = CLS_BRANCH;
            OPC_JAL:    op_cls = CLS_JAL;
            OPC_SYSTEM: if (CSR_EN != 0) op_cls = CLS_SYSTEM;
            default:    op_cls = CLS_ILL;
        endcase
        legal = (op_cls != CLS_ILL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle rv32i control FSM sharing one ALU and one memory port, with trap path.
// Latency 3-5 cycles per instruction plus one per memory wait cycle.
// Holds mem_req until mem_ready or TIMEOUT wait cycles, then traps with a bus fault.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CSR_EN  = 1,
    parameter int TW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op_code,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_w,
    output logic       adr_s,
    output logic       ir_w,
    output logic       pc_w,
    output logic       branch,
    output logic [1:0] pc_s,
    output logic [1:0] alu_a_s,
    output logic [1:0] alu_b_s,
    output logic [1:0] sel,
    output logic [1:0] dato_s,
    output logic [1:0] mocsr,
    output logic       reg_w,
    output logic       trap,
    output logic [1:0] cause,
    output logic       retire
);

    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t      state_q, state_d;
    logic [TW-1:0] to_cnt_q;
    logic [1:0]  cause_q, cause_d;
    ctrl_t       c;
    op_class_t   op_cls;
    logic        op_legal;
    logic        mem_wait;
    logic        to_hit;

    op_class #(.CSR_EN(CSR_EN)) u_op_class (
        .op_code (op_code),
        .op_cls  (op_cls),
        .legal   (op_legal)
    );

    // A wait cycle is one where a request is outstanding and memory did not complete.
    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                      && !mem_ready;
    assign to_hit   = (TIMEOUT != 0) && mem_wait && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cause_d = CAUSE_NONE;
        c       = '0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.adr_s   = ADR_PC;
                c.alu_a_s = A_PC;
                c.alu_b_s = B_FOUR;
                c.sel     = SEL_ADD;
                c.pc_s    = PC_ALU;
                c.ir_w    = mem_ready;
                c.pc_w    = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                c.alu_a_s = A_OLDPC;
                c.alu_b_s = B_IMM;
                c.sel     = SEL_ADD;
                if (!op_legal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILL;
                end else begin
                    case (op_cls)
                        CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
                        CLS_OP:              state_d = S_EXR;
                        CLS_OPIMM:           state_d = S_EXI;
                        CLS_BRANCH:          state_d = S_BEQ;
                        CLS_JAL:             state_d = S_JAL;
                        CLS_SYSTEM:          state_d = S_CSR;
                        default: begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILL;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                c.alu_a_s = A_RS1;
                c.alu_b_s = B_IMM;
                c.sel     = SEL_ADD;
                state_d   = (op_cls == CLS_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.adr_s   = ADR_ALUOUT;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            S_MEMWR: begin
                c.mem_req = 1'b1;
                c.mem_w   = 1'b1;
                c.adr_s   = ADR_ALUOUT;
                c.retire  = mem_ready;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            S_MEMWB: begin
                c.dato_s = WB_MEM;
                c.reg_w  = 1'b1;
                c.retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXR: begin
                c.alu_a_s = A_RS1;
                c.alu_b_s = B_RS2;
                c.sel     = SEL_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXI: begin
                c.alu_a_s = A_RS1;
                c.alu_b_s = B_IMM;
                c.sel     = SEL_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                c.dato_s = WB_ALUOUT;
                c.reg_w  = 1'b1;
                c.retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                c.alu_a_s = A_RS1;
                c.alu_b_s = B_RS2;
                c.sel     = SEL_SUB;
                c.branch  = 1'b1;
                c.pc_s    = PC_ALUOUT;
                c.retire  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                c.pc_w   = 1'b1;
                c.pc_s   = PC_ALUOUT;
                c.dato_s = WB_PC4;
                c.reg_w  = 1'b1;
                c.retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_CSR: begin
                c.dato_s = WB_MEM;
                c.mocsr  = MOCSR_CSR;
                c.reg_w  = 1'b1;
                c.retire = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                c.trap  = 1'b1;
                c.cause = cause_q;
                c.pc_w  = 1'b1;
                c.pc_s  = PC_TRAP;
                state_d = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RST;
            to_cnt_q <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) cause_q <= cause_d;
            // Any state change restarts the wait count for the next transaction.
            if (state_d != state_q) to_cnt_q <= '0;
            else if (mem_wait)      to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    assign mem_req = c.mem_req;
    assign mem_w   = c.mem_w;
    assign adr_s   = c.adr_s;
    assign ir_w    = c.ir_w;
    assign pc_w    = c.pc_w;
    assign branch  = c.branch;
    assign pc_s    = c.pc_s;
    assign alu_a_s = c.alu_a_s;
    assign alu_b_s = c.alu_b_s;
    assign sel     = c.sel;
    assign dato_s  = c.dato_s;
    assign mocsr   = c.mocsr;
    assign reg_w   = c.reg_w;
    assign trap    = c.trap;
    assign cause   = c.cause;
    assign retire  = c.retire;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances (CSR enabled / disabled, TIMEOUT=4)
// driven in lockstep, full output vector compared every cycle.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_w;
        logic       adr_s;
        logic       ir_w;
        logic       pc_w;
        logic       branch;
        logic [1:0] pc_s;
        logic [1:0] alu_a_s;
        logic [1:0] alu_b_s;
        logic [1:0] sel;
        logic [1:0] dato_s;
        logic [1:0] mocsr;
        logic       reg_w;
        logic       trap;
        logic [1:0] cause;
        logic       retire;
    } outv_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op_code;
    logic       mem_ready;
    outv_t      oa, ob;
    int         n_chk  = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4), .CSR_EN(1), .TW(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .mem_req(oa.mem_req), .mem_w(oa.mem_w), .adr_s(oa.adr_s), .ir_w(oa.ir_w),
        .pc_w(oa.pc_w), .branch(oa.branch), .pc_s(oa.pc_s), .alu_a_s(oa.alu_a_s),
        .alu_b_s(oa.alu_b_s), .sel(oa.sel), .dato_s(oa.dato_s), .mocsr(oa.mocsr),
        .reg_w(oa.reg_w), .trap(oa.trap), .cause(oa.cause), .retire(oa.retire)
    );

    multicycle_ctrl #(.TIMEOUT(4), .CSR_EN(0), .TW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .mem_req(ob.mem_req), .mem_w(ob.mem_w), .adr_s(ob.adr_s), .ir_w(ob.ir_w),
        .pc_w(ob.pc_w), .branch(ob.branch), .pc_s(ob.pc_s), .alu_a_s(ob.alu_a_s),
        .alu_b_s(ob.alu_b_s), .sel(ob.sel), .dato_s(ob.dato_s), .mocsr(ob.mocsr),
        .reg_w(ob.reg_w), .trap(ob.trap), .cause(ob.cause), .retire(ob.retire)
    );

    // Field order: mem_req mem_w adr_s ir_w pc_w branch pc_s alu_a alu_b sel dato mocsr reg_w trap cause retire
    function automatic outv_t mk(input logic rq, input logic w, input logic ad, input logic irw,
                                 input logic pcw, input logic br, input logic [1:0] pcs,
                                 input logic [1:0] a, input logic [1:0] b, input logic [1:0] s,
                                 input logic [1:0] d, input logic [1:0] m, input logic rw,
                                 input logic tr, input logic [1:0] ca, input logic rt);
        outv_t v;
        v = '{rq, w, ad, irw, pcw, br, pcs, a, b, s, d, m, rw, tr, ca, rt};
        return v;
    endfunction

    outv_t e_zero, e_fetch_w, e_fetch_r, e_decode, e_memadr, e_memrd, e_memwb;
    outv_t e_memwr_w, e_memwr_r, e_exr, e_exi, e_aluwb, e_beq, e_jal, e_csr, e_trap_ill, e_trap_bus;

    task automatic chk(input string tag, input outv_t obs, input outv_t exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to the next state, apply the inputs for that state, let Mealy outputs settle.
    task automatic cyc(input logic [6:0] op, input logic rdy);
        @(posedge clk);
        #1;
        op_code   = op;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        e_zero     = '0;
        e_fetch_w  = mk(1,0,0,0,0,0,2'b00,2'b00,2'b10,2'b00,2'b00,2'b00,0,0,2'b00,0);
        e_fetch_r  = mk(1,0,0,1,1,0,2'b00,2'b00,2'b10,2'b00,2'b00,2'b00,0,0,2'b00,0);
        e_decode   = mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,2'b00,0,0,2'b00,0);
        e_memadr   = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,2'b00,0,0,2'b00,0);
        e_memrd    = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,2'b00,0);
        e_memwb    = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,1,0,2'b00,1);
        e_memwr_w  = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,2'b00,0);
        e_memwr_r  = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,2'b00,1);
        e_exr      = mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,2'b00,0,0,2'b00,0);
        e_exi      = mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00,2'b00,0,0,2'b00,0);
        e_aluwb    = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1,0,2'b00,1);
        e_beq      = mk(0,0,0,0,0,1,2'b01,2'b10,2'b00,2'b01,2'b00,2'b00,0,0,2'b00,1);
        e_jal      = mk(0,0,0,0,1,0,2'b01,2'b00,2'b00,2'b00,2'b10,2'b00,1,0,2'b00,1);
        e_csr      = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,2'b01,1,0,2'b00,1);
        e_trap_ill = mk(0,0,0,0,1,0,2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,0,1,2'b01,0);
        e_trap_bus = mk(0,0,0,0,1,0,2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,0,1,2'b10,0);

        // Reset: all outputs zero, RST holds through clock edges
        rst_n = 1'b0; op_code = 7'd51; mem_ready = 1'b1;
        #3;
        chk("rst_a", oa, e_zero);
        chk("rst_b", ob, e_zero);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_hold", oa, e_zero);

        // R-type, zero wait: FETCH DECODE EXR ALUWB
        cyc(7'd51, 1); chk("r_fetch", oa, e_fetch_r);
        cyc(7'd51, 1); chk("r_decode", oa, e_decode);
        cyc(7'd51, 1); chk("r_exr", oa, e_exr);
        cyc(7'd51, 1); chk("r_aluwb", oa, e_aluwb);

        // lw with three wait cycles; ready on the 4th wait slot beats TIMEOUT=4
        cyc(7'd3, 1); chk("lw_fetch", oa, e_fetch_r);
        cyc(7'd3, 1); chk("lw_decode", oa, e_decode);
        cyc(7'd3, 1); chk("lw_memadr", oa, e_memadr);
        cyc(7'd3, 0); chk("lw_memrd_w1", oa, e_memrd);
        cyc(7'd3, 0); chk("lw_memrd_w2", oa, e_memrd);
        cyc(7'd3, 0); chk("lw_memrd_w3", oa, e_memrd);
        cyc(7'd3, 1); chk("lw_memrd_rdy", oa, e_memrd);
        cyc(7'd3, 1); chk("lw_memwb", oa, e_memwb);

        // sw, zero wait: retire is combinational on mem_ready in MEMWR
        cyc(7'd35, 1); chk("sw_fetch", oa, e_fetch_r);
        cyc(7'd35, 1); chk("sw_decode", oa, e_decode);
        cyc(7'd35, 1); chk("sw_memadr", oa, e_memadr);
        cyc(7'd35, 1); chk("sw_memwr", oa, e_memwr_r);

        // I-type
        cyc(7'd19, 1); chk("i_fetch", oa, e_fetch_r);
        cyc(7'd19, 1); chk("i_decode", oa, e_decode);
        cyc(7'd19, 1); chk("i_exi", oa, e_exi);
        cyc(7'd19, 1); chk("i_aluwb", oa, e_aluwb);

        // Branch and jal
        cyc(7'd99, 1); chk("b_fetch", oa, e_fetch_r);
        cyc(7'd99, 1); chk("b_decode", oa, e_decode);
        cyc(7'd99, 1); chk("b_beq", oa, e_beq);
        cyc(7'd111, 1); chk("j_fetch", oa, e_fetch_r);
        cyc(7'd111, 1); chk("j_decode", oa, e_decode);
        cyc(7'd111, 1); chk("j_jal", oa, e_jal);

        // SYSTEM: CSR on the enabled instance, illegal trap on the disabled one
        cyc(7'd115, 1); chk("csr_fetch_b", ob, e_fetch_r);
        cyc(7'd115, 1); chk("csr_decode_a", oa, e_decode);
        cyc(7'd115, 1); chk("csr_a", oa, e_csr);
                        chk("csr_trap_b", ob, e_trap_ill);

        // Illegal opcode 7F on both instances
        cyc(7'h7F, 1); chk("ill_fetch", oa, e_fetch_r);
        cyc(7'h7F, 1); chk("ill_decode", oa, e_decode);
        cyc(7'h7F, 1); chk("ill_trap_a", oa, e_trap_ill);
                       chk("ill_trap_b", ob, e_trap_ill);

        // Fetch timeout: four wait cycles then TRAP with bus cause, request dropped
        cyc(7'd51, 0); chk("to_w1", oa, e_fetch_w);
        cyc(7'd51, 0); chk("to_w2", oa, e_fetch_w);
        cyc(7'd51, 0); chk("to_w3", oa, e_fetch_w);
        cyc(7'd51, 0); chk("to_w4", oa, e_fetch_w);
        cyc(7'd51, 0); chk("to_trap", oa, e_trap_bus);
        cyc(7'd51, 0); chk("to_refetch", oa, e_fetch_w);
        cyc(7'd51, 1); chk("to_refetch_rdy", oa, e_fetch_r);

        // Reset pulse in the middle of a stalled store
        cyc(7'd35, 1); chk("rs_decode", oa, e_decode);
        cyc(7'd35, 1); chk("rs_memadr", oa, e_memadr);
        cyc(7'd35, 0); chk("rs_memwr", oa, e_memwr_w);
        rst_n = 1'b0;
        #1;
        chk("rs_async_a", oa, e_zero);
        chk("rs_async_b", ob, e_zero);
        mem_ready = 1'b1;
        #1;
        chk("rs_no_retire", oa, e_zero);
        rst_n = 1'b1;
        cyc(7'd35, 0); chk("rs_fetch", oa, e_fetch_w);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the rv32i core, replacing single-cycle opcode decoding with a Moore/Mealy state machine.
- Sequences fetch, decode, address, memory, execute and writeback over several cycles, sharing one ALU and one memory port.
- Adds a req/ready memory handshake with a parametrised timeout, an illegal-opcode/bus-fault trap path, and a retire pulse.
- Sits in `control_unit/` between the instruction register, the datapath muxes and the memory interface.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum wait cycles on one memory transaction before a bus-fault trap; 0 disables the timeout.
- `CSR_EN`, 1: when 0, opcode 115 is treated as illegal.
- `TW`, 4: width of the timeout counter; must satisfy TIMEOUT < 2^TW.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `op_code` input 7: opcode field of the instruction register.
- `mem_ready` input 1: memory completes the current transaction this cycle.
- `mem_req` output 1: memory transaction request.
- `mem_w` output 1: write request (valid with `mem_req`).
- `adr_s` output 1: memory address source; 0 = PC, 1 = ALU result register.
- `ir_w` output 1: load instruction register.
- `pc_w` output 1: unconditional PC write.
- `branch` output 1: PC write if the ALU zero/compare flag is set.
- `pc_s` output 2: PC source; 00 = ALU, 01 = ALU result register, 10 = trap vector.
- `alu_a_s` output 2: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_b_s` output 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `sel` output 2: ALU decode class; 00 = add, 01 = compare/sub, 10 = funct-decoded.
- `dato_s` output 2: writeback source; 00 = ALU result register, 01 = memory data, 10 = PC+4.
- `mocsr` output 2: 01 selects CSR read data on writeback.
- `reg_w` output 1: register file write.
- `trap` output 1: one-cycle trap pulse.
- `cause` output 2: 01 = illegal opcode, 10 = bus timeout; valid with `trap`, else 00.
- `retire` output 1: one-cycle pulse when an instruction completes.

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, EXI, ALUWB, BEQ, JAL, CSR, TRAP.
- RST:
  - Entered asynchronously while `rst_n`=0; every output is 0.
  - Goes to FETCH on the first edge after deassertion.
- FETCH:
  - Outputs: `mem_req`=1, `adr_s`=0, `alu_a_s`=00, `alu_b_s`=10, `sel`=00, `pc_s`=00.
  - `ir_w` and `pc_w` equal `mem_ready` (Mealy).
  - Moves to DECODE on `mem_ready`.
- DECODE:
  - Outputs: `alu_a_s`=01, `alu_b_s`=01, `sel`=00 (branch target precompute).
  - Next state by opcode: 3/35 → MEMADR, 51 → EXR, 19 → EXI, 99 → BEQ, 111 → JAL, 115 → CSR (if CSR_EN).
  - Any other opcode → TRAP with cause 01.
- MEMADR: `alu_a_s`=10, `alu_b_s`=01, `sel`=00. Goes to MEMRD for opcode 3, MEMWR for opcode 35.
- MEMRD: `mem_req`=1, `adr_s`=1. Moves to MEMWB on `mem_ready`.
- MEMWR: `mem_req`=1, `mem_w`=1, `adr_s`=1. Moves to FETCH with `retire` on `mem_ready`.
- MEMWB: `dato_s`=01, `reg_w`=1, `retire`=1 → FETCH.
- EXR: `alu_a_s`=10, `alu_b_s`=00, `sel`=10 → ALUWB.
- EXI: `alu_a_s`=10, `alu_b_s`=01, `sel`=10 → ALUWB.
- ALUWB: `dato_s`=00, `reg_w`=1, `retire`=1 → FETCH.
- BEQ: `alu_a_s`=10, `alu_b_s`=00, `sel`=01, `branch`=1, `pc_s`=01, `retire`=1 → FETCH.
- JAL: `pc_w`=1, `pc_s`=01, `dato_s`=10, `reg_w`=1, `retire`=1 → FETCH.
- CSR: `dato_s`=01, `mocsr`=01, `reg_w`=1, `retire`=1 → FETCH.
- TRAP:
  - Outputs: `trap`=1, `cause` registered at entry, `pc_w`=1, `pc_s`=10.
  - No `retire`; goes to FETCH.
- Timeout counter:
  - Clears on entry to FETCH/MEMRD/MEMWR and increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When the count reaches TIMEOUT with `mem_ready` still 0, the FSM moves to TRAP with cause 10.
  - `mem_req` drops in TRAP, so the transaction is abandoned.
  - `mem_ready`=1 on the TIMEOUT-th wait cycle wins over the timeout.
- Outputs not listed for a state are 0 (no x-propagation).

## Timing
- Latency with zero-wait memory (`mem_ready` held 1), in cycles:
  - lw: 5.
  - sw: 4.
  - R/I-type: 4.
  - branch, jal, csr: 3.
  - illegal opcode: 3 (FETCH, DECODE, TRAP).
- Each memory wait cycle adds 1.
- `mem_ready` is sampled only while `mem_req`=1; it is ignored in every other state.
- `mem_req` stays high, with stable `mem_w`/`adr_s`, until the cycle `mem_ready`=1 (inclusive) or a timeout.
- `rst_n` asserted mid-instruction: asynchronous return to RST, all outputs 0 in the same cycle, no `retire`.
- `trap` and `retire` are never high together.

## Structure
- `ctrl_pkg` holds:
  - the state enum;
  - opcode constants (LOAD=3, STORE=35, OP=51, OPIMM=19, BRANCH=99, JAL=111, SYSTEM=115);
  - the source-select encodings and cause codes.
- Sub-module `op_class`: combinational opcode → instruction class plus legal flag, honouring CSR_EN. The FSM, counter and output decode stay in `multicycle_ctrl`.

## Test plan
- Reset, then opcode 51 with `mem_ready`=1: states FETCH→DECODE→EXR→ALUWB; `reg_w`=1 and `retire`=1 on the 4th cycle.
- Opcode 3 with `mem_ready` low for 3 cycles in MEMRD: `mem_req`/`adr_s`=1 held for 4 cycles, then MEMWB with `dato_s`=01; 8 cycles total.
- TIMEOUT=4, `mem_ready` stuck 0 in FETCH: `trap`=1, `cause`=10, `pc_s`=10 after 4 wait cycles; `mem_req`=0 in TRAP.
- `op_code`=7'h7F: TRAP on the 3rd cycle with `cause`=01, no `reg_w`, no `retire`. With CSR_EN=0 and opcode 115: same trap.
- `rst_n` pulsed low during MEMWR: all outputs 0 immediately, no `retire`; FETCH on the first edge after release.
